// File: rtl/if_stage_pkg.sv
// Shared pipeline types: IF control codes, NOP word,
// fetch FSM states and the IF/ID bundle.
package pipe_pkg;

  localparam logic [1:0] IF_NORMAL = 2'b00;
  localparam logic [1:0] IF_HOLD   = 2'b01;
  localparam logic [1:0] IF_FLUSH  = 2'b10;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_HELD,
    S_KILL
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] inst;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/ack bus.
// master: fetch side (req, addr out); slave: memory (ack, rdata out).
interface imem_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_stage_id_reg.sv
// IF/ID pipeline register: load d, insert bubble, else hold.
// Ports: clk, rst_n, load, bubble, d (if_id_t), q (if_id_t).
module if_id_reg
  import pipe_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INST = NOP_INST
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t ifid_q, ifid_d;

  always_comb begin
    ifid_d = ifid_q;
    unique case (1'b1)
      bubble: begin
        ifid_d.inst  = BUBBLE_INST;
        ifid_d.valid = 1'b0;
      end
      load:    ifid_d = d;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_q.pc       <= '0;
      ifid_q.pc_plus4 <= '0;
      ifid_q.inst     <= BUBBLE_INST;
      ifid_q.valid    <= 1'b0;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign q = ifid_q;

endmodule

// File: rtl/if_stage.sv
// Fetch stage: pc, imem request FSM, IF/ID register.
// Ports: clk, rst_n, pc_stall, if_ctrl, branch_taken/target,
// imem (imem_if.master), id_pc/pc_plus4/inst/valid, fetch_busy.
// Optional IF_PERF_CNT_EN adds perf_fetch_cnt, perf_bubble_cnt.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = pipe_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_stall,
  input  logic [1:0]  if_ctrl,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  imem_if.master      imem,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        fetch_busy
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  import pipe_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_q, req_d;
  logic [31:0] bpc_q, bpc_d;
  logic [31:0] binst_q, binst_d;

  logic        hold, flush, ack, req_on;
  logic        load, bubble;
  logic [31:0] tgt, req_p4, bpc_p4;
  if_id_t      ld_data, ifid;

  assign hold   = pc_stall | (if_ctrl == IF_HOLD);
  assign flush  = (if_ctrl & IF_FLUSH) != IF_NORMAL;
  assign tgt    = branch_target & 32'hFFFF_FFFC;
  assign ack    = imem.imem_ack;
  assign req_p4 = req_q + 32'd4;
  assign bpc_p4 = bpc_q + 32'd4;

  assign req_on = (state_q == S_REQ)
               || (state_q == S_KILL);

  assign imem.imem_req  = req_on;
  assign imem.imem_addr = req_q;
  assign fetch_busy     = req_on & ~ack;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    bpc_d   = bpc_q;
    binst_d = binst_q;
    load    = 1'b0;
    bubble  = 1'b0;
    ld_data = '{pc:       req_q,
                pc_plus4: req_p4,
                inst:     imem.imem_rdata,
                valid:    1'b1};
    unique case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
        req_d   = pc_q;
        if (branch_taken) begin
          pc_d   = tgt;
          req_d  = tgt;
          bubble = 1'b1;
        end else if (flush) begin
          bubble = 1'b1;
        end
      end
      S_REQ: begin
        if (branch_taken) begin
          pc_d   = tgt;
          bubble = 1'b1;
          if (ack) req_d = tgt;
          else state_d = S_KILL;
        end else if (flush || hold) begin
          // word is parked until IF/ID may take it
          bubble = flush;
          if (ack) begin
            bpc_d   = req_q;
            binst_d = imem.imem_rdata;
            pc_d    = req_p4;
            state_d = S_HELD;
          end
        end else if (ack) begin
          load  = 1'b1;
          pc_d  = req_p4;
          req_d = req_p4;
        end else begin
          bubble = 1'b1;
        end
      end
      S_HELD: begin
        if (branch_taken) begin
          pc_d    = tgt;
          req_d   = tgt;
          bubble  = 1'b1;
          state_d = S_REQ;
        end else if (flush) begin
          bubble = 1'b1;
        end else if (!hold) begin
          load    = 1'b1;
          ld_data = '{pc:       bpc_q,
                      pc_plus4: bpc_p4,
                      inst:     binst_q,
                      valid:    1'b1};
          pc_d    = bpc_p4;
          req_d   = bpc_p4;
          state_d = S_REQ;
        end
      end
      S_KILL: begin
        // drain the stale request, then fetch from pc
        bubble = 1'b1;
        if (branch_taken) pc_d = tgt;
        if (ack) begin
          req_d   = branch_taken ? tgt : pc_q;
          state_d = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      req_q   <= RESET_PC;
      bpc_q   <= '0;
      binst_q <= NOP_INST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      bpc_q   <= bpc_d;
      binst_q <= binst_d;
    end
  end

  if_id_reg #(
    .BUBBLE_INST(NOP_INST)
  ) u_if_id (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .bubble (bubble),
    .d      (ld_data),
    .q      (ifid)
  );

  assign id_pc       = ifid.pc;
  assign id_pc_plus4 = ifid.pc_plus4;
  assign id_inst     = ifid.inst;
  assign id_valid    = ifid.valid;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fcnt_q, fcnt_d;
  logic [31:0] bcnt_q, bcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    bcnt_d = bcnt_q;
    if (state_q == S_REQ && ack && !branch_taken)
      fcnt_d = fcnt_q + 32'd1;
    if (bubble)
      bcnt_d = bcnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      bcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      bcnt_q <= bcnt_d;
    end
  end

  assign perf_fetch_cnt  = fcnt_q;
  assign perf_bubble_cnt = bcnt_q;
`endif

endmodule
